// File: rtl/inv_pkg.sv
// Shared types and constants for the inventory command front-end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package inv_pkg;

    localparam int DATA_W = 8;

    localparam logic MODE_ADD    = 1'b1;
    localparam logic MODE_REMOVE = 1'b0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PARTIAL = 2'd1,
        LOADED  = 2'd2,
        ISSUE   = 2'd3
    } fe_state_t;

    // Resting state implied by the two loaded flags (never ISSUE).
    function automatic fe_state_t state_from_flags(input logic code_ld, input logic qty_ld);
        fe_state_t st;
        case ({code_ld, qty_ld})
            2'b00:   st = IDLE;
            2'b11:   st = LOADED;
            default: st = PARTIAL;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/inv_cmd_frontend_if.sv
// Command handshake bundle between the front-end (master) and the inventory core (slave).
// Latency: n/a (wiring only).
// Backpressure: core holds off a transaction by keeping cmd_ready low; master holds fields stable.
interface inv_cmd_frontend_if #(
    parameter int DATA_W = inv_pkg::DATA_W
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_mode;
    logic [DATA_W-1:0] cmd_code;
    logic [DATA_W-1:0] cmd_qty;

    modport master (
        output cmd_valid,
        output cmd_mode,
        output cmd_code,
        output cmd_qty,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_mode,
        input  cmd_code,
        input  cmd_qty,
        output cmd_ready
    );
endinterface

// File: rtl/button_debouncer.sv
// Synchronises and debounces one active-low push-button; emits a one-cycle press pulse.
// Latency: raw edge to press pulse is 2 (sync) + DEBOUNCE_CYCLES + 1 (pulse register) cycles.
// Backpressure: none; ports are clk, rst, btn_n (raw, asynchronous) and press (pulse out).
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic press
);
    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             level;     // debounced button level, 1 = released
    logic             level_d;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            level   <= 1'b1;
            level_d <= 1'b1;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            sync1   <= btn_n;
            sync2   <= sync1;
            level_d <= level;
            // Pulse only on the debounced released->pressed transition.
            press   <= level_d & ~level;

            // cnt counts consecutive cycles of disagreement; any agreeing
            // cycle restarts it. The level flips on the DEBOUNCE_CYCLES-th
            // disagreeing cycle, so cnt never climbs past CNT_LAST.
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/inv_cmd_frontend.sv
// Operator front-end: debounces save/submit buttons, assembles code/qty/mode, offers it to the core.
// Latency: press pulse to register/flag update 1 cycle; submit pulse to cmd_valid 1 cycle.
// Backpressure: while cmd_valid is high all fields hold until cmd_ready; presses are ignored meanwhile.
// Ports: clk/rst; btn_save_n, btn_submit_n, sw_mode, sw_cq, sw_in raw operator inputs;
//        cmd (master modport: valid/ready/mode/code/qty); code_loaded, qty_loaded, err_pulse status.
module inv_cmd_frontend #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int DATA_W          = inv_pkg::DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  btn_save_n,
    input  logic                  btn_submit_n,
    input  logic                  sw_mode,
    input  logic                  sw_cq,
    input  logic [DATA_W-1:0]     sw_in,
    inv_cmd_frontend_if.master    cmd,
    output logic                  code_loaded,
    output logic                  qty_loaded,
    output logic                  err_pulse
);
    import inv_pkg::*;

    logic save_press;
    logic submit_press;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_save (
        .clk   (clk),
        .rst   (rst),
        .btn_n (btn_save_n),
        .press (save_press)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_submit (
        .clk   (clk),
        .rst   (rst),
        .btn_n (btn_submit_n),
        .press (submit_press)
    );

    // Switch synchronisers. Switches are operator-static, so a plain 2-FF
    // per bit is enough; a bus that is moving while a press lands is the
    // operator's problem, not a metastability one.
    logic              sw_mode_s1, sw_mode_s;
    logic              sw_cq_s1,   sw_cq_s;
    logic [DATA_W-1:0] sw_in_s1,   sw_in_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_mode_s1 <= 1'b0;
            sw_mode_s  <= 1'b0;
            sw_cq_s1   <= 1'b0;
            sw_cq_s    <= 1'b0;
            sw_in_s1   <= '0;
            sw_in_s    <= '0;
        end else begin
            sw_mode_s1 <= sw_mode;
            sw_mode_s  <= sw_mode_s1;
            sw_cq_s1   <= sw_cq;
            sw_cq_s    <= sw_cq_s1;
            sw_in_s1   <= sw_in;
            sw_in_s    <= sw_in_s1;
        end
    end

    fe_state_t         state, state_nxt;
    logic [DATA_W-1:0] code_q, code_nxt;
    logic [DATA_W-1:0] qty_q,  qty_nxt;
    logic              mode_q, mode_nxt;
    logic              code_ld_q, code_ld_nxt;
    logic              qty_ld_q,  qty_ld_nxt;
    logic              err_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            code_q    <= '0;
            qty_q     <= '0;
            mode_q    <= 1'b0;
            code_ld_q <= 1'b0;
            qty_ld_q  <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            state     <= state_nxt;
            code_q    <= code_nxt;
            qty_q     <= qty_nxt;
            mode_q    <= mode_nxt;
            code_ld_q <= code_ld_nxt;
            qty_ld_q  <= qty_ld_nxt;
            err_pulse <= err_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        code_nxt    = code_q;
        qty_nxt     = qty_q;
        mode_nxt    = mode_q;
        code_ld_nxt = code_ld_q;
        qty_ld_nxt  = qty_ld_q;
        err_nxt     = 1'b0;

        case (state)
            ISSUE: begin
                // Presses are ignored here. Code/qty keep their values after
                // the handshake; only the flags say whether they are fresh.
                if (cmd.cmd_ready) begin
                    code_ld_nxt = 1'b0;
                    qty_ld_nxt  = 1'b0;
                    state_nxt   = IDLE;
                end
            end
            default: begin
                // Save wins over a coincident submit; the submit is dropped
                // without an error so the operator simply presses it again.
                if (save_press) begin
                    if (sw_cq_s) begin
                        code_nxt    = sw_in_s;
                        code_ld_nxt = 1'b1;
                    end else begin
                        qty_nxt     = sw_in_s;
                        qty_ld_nxt  = 1'b1;
                    end
                    state_nxt = state_from_flags(code_ld_nxt, qty_ld_nxt);
                end else if (submit_press) begin
                    if (state == LOADED) begin
                        mode_nxt  = sw_mode_s;
                        state_nxt = ISSUE;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
        endcase
    end

    // Decoded straight from the state register so rst drops it immediately.
    assign cmd.cmd_valid = (state == ISSUE);
    assign cmd.cmd_mode  = mode_q;
    assign cmd.cmd_code  = code_q;
    assign cmd.cmd_qty   = qty_q;
    assign code_loaded   = code_ld_q;
    assign qty_loaded    = qty_ld_q;

endmodule

// File: doc/inv_cmd_frontend.md
Name: inv_cmd_frontend

Overview:
- Front-end stage directly upstream of the inventory core.
- Conditions the raw push-buttons and switches and assembles a complete add/remove transaction (item code, quantity, mode).
- Presents the transaction to the core over a valid/ready handshake.
- Replaces direct button-edge clocking with a single synchronous clock domain and gives the operator status and error feedback.

Parameters:
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles required before a button change is accepted (sim: 4)
- DATA_W, 8, width of code and quantity fields

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- btn_save_n  input  1  raw save button, active-low, asynchronous
- btn_submit_n  input  1  raw submit button, active-low, asynchronous
- sw_mode  input  1  1 = add, 0 = remove (asynchronous switch)
- sw_cq  input  1  1 = switches carry code, 0 = quantity
- sw_in  input  DATA_W  data switches
- cmd_valid  output  1  transaction offered to core
- cmd_ready  input  1  core accepts transaction
- cmd_mode  output  1  captured mode
- cmd_code  output  DATA_W  captured item code
- cmd_qty  output  DATA_W  captured quantity
- code_loaded  output  1  code register holds an operator value
- qty_loaded  output  1  quantity register holds an operator value
- err_pulse  output  1  one-cycle pulse on rejected submit

Behaviour:
- Reset: one clock, asynchronous, active-high. While rst is high, all outputs are 0, the FSM is in IDLE, debouncers report "released", and the flags are cleared. This takes effect immediately, including mid-handshake: cmd_valid drops asynchronously.
- Synchronisation: every button and switch passes through a 2-FF synchroniser before use.
- Debounce:
  - Debounced level changes only after the synchronised input differs from the current debounced level for DEBOUNCE_CYCLES consecutive cycles.
  - Any glitch restarts the counter.
  - Counter saturates; no wrap.
- Press pulse: a one-cycle press pulse is generated on the debounced 1->0 transition.
  - Latency from a clean raw edge to the pulse is 2 + DEBOUNCE_CYCLES + 1 cycles.
- FSM states:
  - IDLE: neither field loaded.
  - PARTIAL: exactly one field loaded.
  - LOADED: both fields loaded.
  - ISSUE: cmd_valid high.
- Save press, in IDLE/PARTIAL/LOADED:
  - If sw_cq=1: cmd_code <= sw_in, code_loaded <= 1.
  - Otherwise: cmd_qty <= sw_in, qty_loaded <= 1.
  - Reloading an already-loaded field overwrites it.
  - Next state follows from the flags.
- Submit press:
  - In LOADED: cmd_mode <= sw_mode, go to ISSUE; cmd_valid rises on the next cycle.
  - In IDLE or PARTIAL: err_pulse = 1 for exactly one cycle; state and registers are unchanged.
- ISSUE:
  - cmd_valid, cmd_mode, cmd_code and cmd_qty are held stable until cmd_valid && cmd_ready.
  - On that cycle: clear both loaded flags, go to IDLE, cmd_valid=0 on the following cycle.
  - cmd_code and cmd_qty keep their last values; they are only meaningful while cmd_valid is high.
- Presses during ISSUE are ignored: no err, no register change.
- Simultaneous save and submit pulses in the same cycle: save is applied and submit is dropped silently.
- cmd_ready high while cmd_valid is low has no effect.
- Quantity range checking (saturation at 255 / floor at 0) is the core's responsibility. This block passes values unmodified.

Decomposition:
- Package inv_pkg holds:
  - DATA_W constant
  - typedef enum for fe_state_t {IDLE, PARTIAL, LOADED, ISSUE}
  - MODE_ADD / MODE_REMOVE constants
- Sub-module button_debouncer (params DEBOUNCE_CYCLES):
  - contains the 2-FF synchroniser, stability counter, debounced level and press pulse.
  - instantiated twice.
- Switches use plain synchronisers in the top level.

Test Plan:
- Debounce glitch, DEBOUNCE_CYCLES=4: btn_save_n low for 3 cycles then high -> no press pulse, code_loaded stays 0. Then low for 6 cycles -> exactly one pulse, 7 cycles after the edge.
- Normal add: save with sw_cq=1, sw_in=8'h2A, then save with sw_cq=0, sw_in=8'd10, then submit with sw_mode=1 and cmd_ready=0 for 5 cycles -> cmd_valid=1 and cmd_code=8'h2A, cmd_qty=8'd10, cmd_mode=1 held stable. Raise cmd_ready -> valid drops next cycle, both loaded flags read 0.
- Early submit: save code only, then submit -> err_pulse high for 1 cycle, no cmd_valid, code_loaded still 1.
- Ignored press during ISSUE: while cmd_valid=1, save with sw_in=8'hFF -> cmd_code unchanged, no err_pulse.
- Simultaneous presses: both pulses coincide with sw_cq=0, sw_in=8'd3 in PARTIAL(code) -> qty_loaded=1, state LOADED, cmd_valid stays 0.
- Reset mid-handshake: assert rst while cmd_valid=1 -> cmd_valid=0 and flags=0 within the same cycle (asynchronous). After release, a submit press gives err_pulse.
